// File: rtl/reg_dest_pkg.sv
// Shared encodings and types for the register-destination pipeline.
package reg_dest_pkg;

    localparam logic [1:0] RD_SEL_RT   = 2'b00;
    localparam logic [1:0] RD_SEL_RD   = 2'b01;
    localparam logic [1:0] RD_SEL_RS   = 2'b10;
    localparam logic [1:0] RD_SEL_LINK = 2'b11;

    localparam int FWD_W      = 3;
    // Stage entries carry the widest supported address; narrower files zero-extend.
    localparam int ADDR_W_MAX = 8;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [ADDR_W_MAX-1:0] addr;
    } stage_t;

endpackage

// File: rtl/reg_dest_pipe_if.sv
// Decode-side inputs and write-back / hazard outputs of reg_dest_pipe.
interface reg_dest_pipe_if
    import reg_dest_pkg::*;
#(
    parameter int ADDR_W = 3
);
    logic                  in_valid;
    logic                  reg_write;
    logic [1:0]            regDest;
    logic [ADDR_W-1:0]     rs;
    logic [ADDR_W-1:0]     rt;
    logic [ADDR_W-1:0]     rd;
    logic                  stall;
    logic                  flush;
    logic [ADDR_W-1:0]     src_a;
    logic [ADDR_W-1:0]     src_b;
    logic [ADDR_W-1:0]     dest_addr;
    logic [ADDR_W-1:0]     wb_addr;
    logic                  wb_we;
    logic [2**ADDR_W-1:0]  pending;
    logic [FWD_W-1:0]      fwd_a;
    logic [FWD_W-1:0]      fwd_b;
    logic                  hazard;

    modport master (
        output in_valid, reg_write, regDest, rs, rt, rd, stall, flush, src_a, src_b,
        input  dest_addr, wb_addr, wb_we, pending, fwd_a, fwd_b, hazard
    );

    modport slave (
        input  in_valid, reg_write, regDest, rs, rt, rd, stall, flush, src_a, src_b,
        output dest_addr, wb_addr, wb_we, pending, fwd_a, fwd_b, hazard
    );
endinterface

// File: rtl/reg_dest_sel.sv
// Combinational write-back destination select from the decode-stage regDest code.
module reg_dest_sel
    import reg_dest_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter bit LINK_EN  = 1'b0,
    parameter int LINK_REG = 7
) (
    input  logic [1:0]        regDest,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    output logic [ADDR_W-1:0] dest
);

    always_comb begin
        dest = rt;
        unique case (regDest)
            RD_SEL_RT:   dest = rt;
            RD_SEL_RD:   dest = rd;
            RD_SEL_RS:   dest = rs;
            // Legacy decoders without a link register treat 2'b11 as rs.
            RD_SEL_LINK: dest = LINK_EN ? ADDR_W'(LINK_REG) : rs;
        endcase
    end

endmodule

// File: rtl/reg_dest_pipe.sv
// Destination select, {valid, we, addr} pipeline to write-back, pending-write
// scoreboard and youngest-producer forwarding selects.
module reg_dest_pipe
    import reg_dest_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int STAGES      = 3,
    parameter bit LINK_EN     = 1'b0,
    parameter int LINK_REG    = 7,
    parameter bit ZERO_IGNORE = 1'b1
) (
    input logic            clk,
    input logic            rst,
    reg_dest_pipe_if.slave bus
);

    localparam int NREG = 1 << ADDR_W;

    logic [ADDR_W-1:0] dest;
    logic              cap_we;
    stage_t            stage_in [STAGES];
    stage_t            stage_q  [STAGES];
    logic [STAGES-1:0] match_a;
    logic [STAGES-1:0] match_b;
    logic [FWD_W-1:0]  fwd_a_comb;
    logic [FWD_W-1:0]  fwd_b_comb;

    reg_dest_sel #(
        .ADDR_W   (ADDR_W),
        .LINK_EN  (LINK_EN),
        .LINK_REG (LINK_REG)
    ) u_sel (
        .regDest (bus.regDest),
        .rs      (bus.rs),
        .rt      (bus.rt),
        .rd      (bus.rd),
        .dest    (dest)
    );

    assign bus.dest_addr = dest;
    assign cap_we = bus.reg_write & bus.in_valid & ~(ZERO_IGNORE & (dest == '0));
    assign stage_in[0] = '{valid: bus.in_valid, we: cap_we, addr: ADDR_W_MAX'(dest)};

    genvar gi;
    generate
        for (gi = 1; gi < STAGES; gi++) begin : g_link
            assign stage_in[gi] = stage_q[gi-1];
        end

        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            stage_t entry_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (bus.flush) begin
                    // Address is left stale; only valid/we matter once killed.
                    entry_reg.valid <= 1'b0;
                    entry_reg.we    <= 1'b0;
                end else if (!bus.stall) begin
                    entry_reg <= stage_in[gi];
                end
            end

            assign stage_q[gi] = entry_reg;
            assign match_a[gi] = entry_reg.valid & entry_reg.we &
                                 (entry_reg.addr == ADDR_W_MAX'(bus.src_a));
            assign match_b[gi] = entry_reg.valid & entry_reg.we &
                                 (entry_reg.addr == ADDR_W_MAX'(bus.src_b));
        end

        for (gi = 0; gi < NREG; gi++) begin : g_pend
            logic [STAGES-1:0] hit;
            for (genvar gj = 0; gj < STAGES; gj++) begin : g_hit
                assign hit[gj] = stage_q[gj].valid & stage_q[gj].we &
                                 (stage_q[gj].addr == ADDR_W_MAX'(gi));
            end
            assign bus.pending[gi] = |hit;
        end
    endgenerate

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        fwd_a_comb = '0;
        fwd_b_comb = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (match_a[i]) fwd_a_comb = FWD_W'(i + 1);
            if (match_b[i]) fwd_b_comb = FWD_W'(i + 1);
        end
        if (ZERO_IGNORE && (bus.src_a == '0)) fwd_a_comb = '0;
        if (ZERO_IGNORE && (bus.src_b == '0)) fwd_b_comb = '0;
    end

    assign bus.fwd_a   = fwd_a_comb;
    assign bus.fwd_b   = fwd_b_comb;
    assign bus.hazard  = (fwd_a_comb == FWD_W'(1)) | (fwd_b_comb == FWD_W'(1));
    assign bus.wb_addr = stage_q[STAGES-1].addr[ADDR_W-1:0];
    assign bus.wb_we   = stage_q[STAGES-1].valid & stage_q[STAGES-1].we;

endmodule

// File: tb/tb_reg_dest_pipe.sv
// Self-checking bench for reg_dest_pipe: select table, scoreboard stream, corner sequences.
module tb_reg_dest_pipe;
    import reg_dest_pkg::*;

    localparam int AW = 3;
    localparam int ST = 3;
    localparam int NV = 8;

    typedef struct {
        logic [1:0]    sel;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic          rw;
        logic [AW-1:0] exp_dest;
        logic [AW-1:0] exp_link;
        logic          exp_we;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [NV];
    exp_t sb_q [$];
    exp_t e;

    always #5 clk = ~clk;

    reg_dest_pipe_if #(.ADDR_W(AW)) bus ();
    reg_dest_pipe_if #(.ADDR_W(AW)) bus_l ();

    reg_dest_pipe #(
        .ADDR_W(AW), .STAGES(ST), .LINK_EN(1'b0), .LINK_REG(7), .ZERO_IGNORE(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    reg_dest_pipe #(
        .ADDR_W(AW), .STAGES(ST), .LINK_EN(1'b1), .LINK_REG(7), .ZERO_IGNORE(1'b1)
    ) dut_link (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    assign bus_l.regDest   = bus.regDest;
    assign bus_l.rs        = bus.rs;
    assign bus_l.rt        = bus.rt;
    assign bus_l.rd        = bus.rd;
    assign bus_l.in_valid  = 1'b0;
    assign bus_l.reg_write = 1'b0;
    assign bus_l.stall     = 1'b0;
    assign bus_l.flush     = 1'b0;
    assign bus_l.src_a     = '0;
    assign bus_l.src_b     = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [1:0] sel,
                         input logic [AW-1:0] s, input logic [AW-1:0] t, input logic [AW-1:0] d);
        bus.in_valid  = v;
        bus.reg_write = w;
        bus.regDest   = sel;
        bus.rs        = s;
        bus.rt        = t;
        bus.rd        = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, '0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //             sel    rs    rt    rd    rw    dest  link  we
        vecs[0] = '{2'b00, 3'd1, 3'd2, 3'd3, 1'b1, 3'd2, 3'd2, 1'b1};
        vecs[1] = '{2'b01, 3'd1, 3'd2, 3'd3, 1'b1, 3'd3, 3'd3, 1'b1};
        vecs[2] = '{2'b10, 3'd1, 3'd2, 3'd3, 1'b1, 3'd1, 3'd1, 1'b1};
        vecs[3] = '{2'b11, 3'd1, 3'd2, 3'd3, 1'b1, 3'd1, 3'd7, 1'b1};
        vecs[4] = '{2'b01, 3'd5, 3'd6, 3'd0, 1'b1, 3'd0, 3'd0, 1'b0};
        vecs[5] = '{2'b00, 3'd4, 3'd7, 3'd5, 1'b0, 3'd7, 3'd7, 1'b0};
        vecs[6] = '{2'b10, 3'd6, 3'd1, 3'd2, 1'b1, 3'd6, 3'd6, 1'b1};
        vecs[7] = '{2'b11, 3'd3, 3'd4, 3'd5, 1'b1, 3'd3, 3'd7, 1'b1};

        rst = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.src_a = 3'd3;
        bus.src_b = 3'd5;
        idle();
        tick();
        tick();
        check("rst_wb_we",   int'(bus.wb_we),   0);
        check("rst_wb_addr", int'(bus.wb_addr), 0);
        check("rst_pending", int'(bus.pending), 0);
        check("rst_fwd_a",   int'(bus.fwd_a),   0);
        check("rst_fwd_b",   int'(bus.fwd_b),   0);
        check("rst_hazard",  int'(bus.hazard),  0);
        rst = 1'b0;

        // Table stream: select checked at decode, write-back checked via scoreboard.
        for (int j = 0; j < NV + ST; j++) begin
            if (j < NV) begin
                drive(1'b1, vecs[j].rw, vecs[j].sel, vecs[j].rs, vecs[j].rt, vecs[j].rd);
                #1;
                check($sformatf("sel_dest[%0d]", j), int'(bus.dest_addr), int'(vecs[j].exp_dest));
                check($sformatf("sel_link[%0d]", j), int'(bus_l.dest_addr), int'(vecs[j].exp_link));
                sb_q.push_back('{addr: vecs[j].exp_dest, we: vecs[j].exp_we});
            end else begin
                idle();
            end
            tick();
            if (j >= ST - 1 && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_wb_addr", int'(bus.wb_addr), int'(e.addr));
                check("sb_wb_we",   int'(bus.wb_we),   int'(e.we));
                $display("wb txn addr=%0d we=%0d (exp addr=%0d we=%0d)",
                         bus.wb_addr, bus.wb_we, e.addr, e.we);
            end
        end

        // Latency: single write to r5 visible at wb after exactly ST edges.
        drive(1'b1, 1'b1, 2'b01, 3'd0, 3'd0, 3'd5);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) idle();
            check($sformatf("lat_wb_we[%0d]", k), int'(bus.wb_we), (k == 3) ? 1 : 0);
            check($sformatf("lat_pend5[%0d]", k), int'(bus.pending[5]), (k <= 3) ? 1 : 0);
            if (k == 3) check("lat_wb_addr", int'(bus.wb_addr), 5);
            if (k == 2) check("lat_pending", int'(bus.pending), 32);
        end
        $display("latency txn done");

        // Forwarding priority: two writes to r4 back to back.
        bus.src_a = 3'd4;
        bus.src_b = 3'd0;
        drive(1'b1, 1'b1, 2'b01, 3'd0, 3'd0, 3'd4);
        tick();
        tick();
        idle();
        check("fwd_a_young", int'(bus.fwd_a),  1);
        check("fwd_hazard1", int'(bus.hazard), 1);
        check("fwd_b_zero",  int'(bus.fwd_b),  0);
        tick();
        check("fwd_a_next",  int'(bus.fwd_a),  2);
        check("fwd_hazard0", int'(bus.hazard), 0);
        bus.src_b = 3'd4;
        #1;
        check("fwd_b_next",  int'(bus.fwd_b),  2);
        tick();
        check("fwd_a_old",   int'(bus.fwd_a),  3);
        tick();
        check("fwd_a_gone",  int'(bus.fwd_a),  0);
        $display("forward txn done");
        bus.src_a = 3'd3;
        bus.src_b = 3'd5;

        // Stall two edges while r6 is in stage 0: wb arrives two edges late.
        drive(1'b1, 1'b1, 2'b01, 3'd0, 3'd0, 3'd6);
        tick();
        idle();
        bus.stall = 1'b1;
        for (int k = 2; k <= 6; k++) begin
            tick();
            if (k == 3) bus.stall = 1'b0;
            check($sformatf("stall_wb_we[%0d]", k), int'(bus.wb_we), (k == 5) ? 1 : 0);
            if (k == 5) check("stall_wb_addr", int'(bus.wb_addr), 6);
        end
        $display("stall txn done");

        // Flush with stall: entry at wb still visible, everything gone after the edge.
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 1'b1, 2'b01, 3'd0, 3'd0, 3'(k));
            tick();
        end
        idle();
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        #1;
        check("flush_pre_we",   int'(bus.wb_we),   1);
        check("flush_pre_addr", int'(bus.wb_addr), 1);
        check("flush_pre_pend", int'(bus.pending), 14);
        tick();
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        check("flush_pending", int'(bus.pending), 0);
        check("flush_wb_we",   int'(bus.wb_we),   0);
        $display("flush txn done");

        // Zero register write is dropped.
        drive(1'b1, 1'b1, 2'b01, 3'd5, 3'd6, 3'd0);
        #1;
        check("zero_dest", int'(bus.dest_addr), 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) idle();
            check($sformatf("zero_wb_we[%0d]", k), int'(bus.wb_we), 0);
            check($sformatf("zero_pend0[%0d]", k), int'(bus.pending[0]), 0);
        end
        $display("zero txn done");

        // Reset mid-flight discards the in-flight write.
        drive(1'b1, 1'b1, 2'b01, 3'd0, 3'd0, 3'd5);
        tick();
        idle();
        check("mrst_pre_pend", int'(bus.pending), 32);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_pending", int'(bus.pending), 0);
        for (int k = 3; k <= 4; k++) begin
            tick();
            check($sformatf("mrst_wb_we[%0d]", k), int'(bus.wb_we), 0);
        end
        $display("reset txn done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_dest_pipe.md
Name: reg_dest_pipe

Overview:
- Parametrised successor to the combinational register-destination select.
- Selects the write-back destination (rs/rt/rd or a fixed link register) from the decode-stage regDest code, then carries {addr, we, valid} through STAGES pipeline registers to write-back.
- Also provides a pending-write scoreboard and per-source forwarding selects for the hazard unit.
- Sits between decode and the register file write port.

Parameters:
- ADDR_W, 3, register address width (register file has 2**ADDR_W entries).
- STAGES, 3, pipeline registers between decode and write-back (EX, MEM, WB); legal range 1..6.
- LINK_EN, 0, 1: regDest 2'b11 selects LINK_REG; 0: 2'b11 selects rs (legacy encoding).
- LINK_REG, 7, link register address used when LINK_EN=1.
- ZERO_IGNORE, 1, 1: a destination of address 0 forces we=0 at capture.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  decode-stage instruction present.
- reg_write  in  1  decode-stage instruction writes a register.
- regDest  in  2  select: 2'b1x rs (2'b11 LINK_REG when LINK_EN), 2'b01 rd, 2'b00 rt.
- rs, rt, rd  in  ADDR_W each  decode-stage register fields.
- stall  in  1  hold all stages.
- flush  in  1  kill all in-flight entries.
- src_a, src_b  in  ADDR_W each  source registers of the instruction in decode.
- dest_addr  out  ADDR_W  combinational selected destination (decode-stage view).
- wb_addr  out  ADDR_W  write-back address (last stage).
- wb_we  out  1  write-back enable (last stage valid & we).
- pending  out  2**ADDR_W  bit r set if any stage holds valid&we to register r.
- fwd_a, fwd_b  out  3  0 = no match; k = youngest stage index (k-1) holding valid&we to that source.
- hazard  out  1  fwd_a!=0 or fwd_b!=0 with matching stage 0 (load-use style; the pipeline controller decides what to do with it).

Behaviour:
- Decode select is combinational and drives dest_addr:
  - regDest[1]=1 → rs, or LINK_REG if LINK_EN and regDest[0]=1.
  - Otherwise regDest[0]=1 → rd, else rt.
- Capture term: cap_we = reg_write & in_valid & ~(ZERO_IGNORE & dest==0).
- Stage registers stage[0..STAGES-1] each hold {valid, we, addr}.
- Each edge, unless stall or flush:
  - stage[0] <= {in_valid, cap_we, dest}.
  - stage[i] <= stage[i-1].
- stall=1 (flush=0): all stages hold. wb_we stays asserted if held, so the register file rewrites the same value; this is idempotent and allowed.
- flush=1: all stages clear valid/we at the edge. flush overrides stall. The entry currently visible at wb_* still commits this cycle.
- rst=1: all valid/we/addr clear at the edge and rst overrides flush/stall. After reset: wb_addr=0, wb_we=0, pending=0, fwd_a=fwd_b=0, hazard=0. Reset mid-stream discards all in-flight entries.
- Latency: a decode-stage instruction reaches wb_* exactly STAGES unstalled edges after capture.
- wb_addr = stage[STAGES-1].addr; wb_we = stage[STAGES-1].valid & stage[STAGES-1].we.
- pending: OR over stages of one-hot(addr) gated by valid&we. Derived combinationally from registered state only, so it does not depend on current decode inputs.
- Forwarding: scan stages 0..STAGES-1 and report the lowest index that matches (youngest producer wins). src==0 with ZERO_IGNORE=1 always yields 0.
- Multiple stages writing the same register: pending shows a single bit; fwd reports the youngest.
- No internal wrap or overflow conditions; depth is fixed by STAGES.

Decomposition:
- Shared package reg_dest_pkg:
  - regDest encodings RD_SEL_RT=2'b00, RD_SEL_RD=2'b01, RD_SEL_RS=2'b10, RD_SEL_LINK=2'b11.
  - Stage entry struct {valid, we, addr}.
  - fwd code width constant (3).
- One natural sub-module: reg_dest_sel, the combinational select carrying the LINK_EN/LINK_REG parameters. Stages, scoreboard and forwarding stay in the top level as generate loops.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → wb_we=0, wb_addr=0, pending=0, fwd_a=fwd_b=0.
- Select coverage: rs=1, rt=2, rd=3, regDest=00/01/10/11 (LINK_EN=0) → dest_addr=2/3/1/1. With LINK_EN=1, LINK_REG=7, regDest=11 → 7.
- Latency: capture rd=5, reg_write=1 at cycle 0, STAGES=3 → wb_addr=5, wb_we=1 at cycle 3 only. pending[5]=1 during cycles 1..3.
- Forwarding priority: write r4 at cycles 0 and 1, then src_a=4 → fwd_a=1 (stage 0) and hazard=1. One cycle later → fwd_a=2.
- Stall/flush: stall 2 cycles mid-flight → wb arrives 2 cycles late with unchanged addr. Assert flush and stall together → all entries gone next cycle, pending=0.
- Zero register: rd=0, regDest=01, reg_write=1 with ZERO_IGNORE=1 → wb_we never asserted, pending[0]=0. rst asserted mid-flight → pending=0 next edge.
